mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the CPU's instruction-fetch path and its load/store data path. It serialises the two requesters through a registered request/ready handshake and drives a stall signal that freezes the PC and register-file write while either access is outstanding. Data accesses win simultaneous requests. An optional watchdog bounds memory latency.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for one single-ported memory, data first; watchdog built with MEM_ARB_WATCHDOG_EN
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic [DW-1:0] m_rdata,
   output logic          stall,
   output logic          err
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state, state_n;
   logic own, own_n, m_req_n, m_we_n, err_n, tmo;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] wdata_n, i_rdata_n, d_rdata_n, rd;
`ifdef MEM_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt, cnt_n;
   assign tmo = state == BUSY && !m_ready && cnt == CW'(TIMEOUT - 1);
   assign cnt_n = state != BUSY ? '0 : m_ready ? cnt : cnt + 1'b1;
   assign err_n = err | tmo;
   always_ff @(posedge CLK)
      cnt <= !RST ? '0 : cnt_n;
`else
   assign tmo = TIMEOUT < 0;
   assign err_n = 1'b0;
`endif
   assign rd = m_ready ? m_rdata : DW'(32'hDEADBEEF);
   assign i_done = state == RESP && !own;
   assign d_done = state == RESP && own;
   assign stall = (i_req & ~i_done) | (d_req & ~d_done);
   always_comb begin
      state_n = state;
      own_n = own;
      m_req_n = m_req;
      m_we_n = m_we;
      addr_n = m_addr;
      wdata_n = m_wdata;
      i_rdata_n = i_rdata;
      d_rdata_n = d_rdata;
      if (state == IDLE && d_req) begin
         state_n = BUSY;
         own_n = 1'b1;
         m_req_n = 1'b1;
         m_we_n = d_we;
         addr_n = d_addr;
         wdata_n = d_wdata;
      end else if (state == IDLE && i_req) begin
         state_n = BUSY;
         own_n = 1'b0;
         m_req_n = 1'b1;
         m_we_n = 1'b0;
         addr_n = i_addr;
      end else if (state == BUSY && (m_ready || tmo)) begin
         state_n = RESP;
         m_req_n = 1'b0;
         i_rdata_n = !own ? rd : i_rdata;
         d_rdata_n = own && !m_we ? rd : d_rdata;
      end else if (state == RESP) begin
         state_n = IDLE;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         own <= 1'b0;
         m_req <= 1'b0;
         m_we <= 1'b0;
         m_addr <= '0;
         m_wdata <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         own <= own_n;
         m_req <= m_req_n;
         m_we <= m_we_n;
         m_addr <= addr_n;
         m_wdata <= wdata_n;
         i_rdata <= i_rdata_n;
         d_rdata <= d_rdata_n;
         err <= err_n;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int TIMEOUT = 15;
`ifdef MEM_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif
   logic CLK = 1'b0, RST = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
   logic i_done, d_done, m_req, m_we, stall, err;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   int nvec = 0, nerr = 0;
   bit chk_en = 1'b0;
   bit mq = 1'b0, own_m = 1'b0, we_m = 1'b0, err_m = 1'b0;
   int dn = -1, wc = 0;
   logic [31:0] addr_m = '0, wdata_m = '0, ir_m = '0, dr_m = '0;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata), .stall(stall), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // transaction-level view: one outstanding memory access, then one done cycle
   always @(posedge CLK) begin
      if (!RST) begin
         mq <= 1'b0; dn <= -1; own_m <= 1'b0; we_m <= 1'b0; addr_m <= '0;
         wdata_m <= '0; ir_m <= '0; dr_m <= '0; err_m <= 1'b0; wc <= 0;
      end else if (dn >= 0) begin
         dn <= -1;
      end else if (mq) begin
         if (m_ready || (WD && wc + 1 == TIMEOUT)) begin
            mq <= 1'b0;
            dn <= int'(own_m);
            if (!own_m) ir_m <= m_ready ? m_rdata : 32'hDEADBEEF;
            else if (!we_m) dr_m <= m_ready ? m_rdata : 32'hDEADBEEF;
            if (!m_ready) err_m <= 1'b1;
         end else begin
            wc <= wc + 1;
         end
      end else if (d_req) begin
         mq <= 1'b1; own_m <= 1'b1; we_m <= d_we; addr_m <= d_addr; wdata_m <= d_wdata; wc <= 0;
      end else if (i_req) begin
         mq <= 1'b1; own_m <= 1'b0; we_m <= 1'b0; addr_m <= i_addr; wc <= 0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("m_req", {31'b0, m_req}, {31'b0, mq});
         chk("m_we", {31'b0, m_we}, {31'b0, we_m});
         chk("m_addr", m_addr, addr_m);
         chk("m_wdata", m_wdata, wdata_m);
         chk("i_done", {31'b0, i_done}, {31'b0, dn == 0});
         chk("d_done", {31'b0, d_done}, {31'b0, dn == 1});
         chk("i_rdata", i_rdata, ir_m);
         chk("d_rdata", d_rdata, dr_m);
         chk("stall", {31'b0, stall}, {31'b0, (i_req && dn != 0) || (d_req && dn != 1)});
         chk("err", {31'b0, err}, {31'b0, err_m});
      end
   end

   initial begin
      int k;
      step();
      @(negedge CLK);
      chk("rst_m_req", {31'b0, m_req}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      RST = 1'b1;
      chk_en = 1'b1;
      step();
      // single fetch
      step(); i_req = 1'b1; i_addr = 32'h0040_0000;
      @(negedge CLK); chk("f_stall_c0", {31'b0, stall}, 32'd1);
      step(); m_ready = 1'b1; m_rdata = 32'h2008_0005;
      @(negedge CLK);
      chk("f_m_req_c1", {31'b0, m_req}, 32'd1);
      chk("f_m_addr", m_addr, 32'h0040_0000);
      chk("f_m_we", {31'b0, m_we}, 32'd0);
      chk("f_stall_c1", {31'b0, stall}, 32'd1);
      step(); m_ready = 1'b0;
      @(negedge CLK);
      chk("f_i_done_c2", {31'b0, i_done}, 32'd1);
      chk("f_i_rdata", i_rdata, 32'h2008_0005);
      chk("f_stall_c2", {31'b0, stall}, 32'd0);
      step(); i_req = 1'b0;
      @(negedge CLK); chk("f_i_done_c3", {31'b0, i_done}, 32'd0);
      // collision: data first
      step(); i_req = 1'b1; i_addr = 32'h0040_0004; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0000;
      step(); m_ready = 1'b1; m_rdata = 32'h1111_2222;
      @(negedge CLK); chk("c_m_addr_d", m_addr, 32'h1001_0000);
      step(); m_ready = 1'b0;
      @(negedge CLK);
      chk("c_d_done_c2", {31'b0, d_done}, 32'd1);
      chk("c_d_rdata", d_rdata, 32'h1111_2222);
      step(); d_req = 1'b0;
      @(negedge CLK); chk("c_m_req_c3", {31'b0, m_req}, 32'd0);
      step(); m_ready = 1'b1; m_rdata = 32'h3333_4444;
      @(negedge CLK);
      chk("c_m_req_c4", {31'b0, m_req}, 32'd1);
      chk("c_m_addr_i", m_addr, 32'h0040_0004);
      step(); m_ready = 1'b0;
      @(negedge CLK);
      chk("c_i_done_c5", {31'b0, i_done}, 32'd1);
      chk("c_i_rdata", i_rdata, 32'h3333_4444);
      step(); i_req = 1'b0;
      // store with three wait cycles
      step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hCAFE_F00D;
      for (int c = 1; c <= 4; c++) begin
         step(); m_ready = c == 4; m_rdata = 32'h5555_6666;
         @(negedge CLK);
         chk("s_m_req", {31'b0, m_req}, 32'd1);
         chk("s_m_we", {31'b0, m_we}, 32'd1);
         chk("s_m_wdata", m_wdata, 32'hCAFE_F00D);
      end
      step(); m_ready = 1'b0;
      @(negedge CLK);
      chk("s_d_done_c5", {31'b0, d_done}, 32'd1);
      chk("s_d_rdata_kept", d_rdata, 32'h1111_2222);
      step(); d_req = 1'b0; d_we = 1'b0;
      // reset in the middle of an access
      step(); i_req = 1'b1; i_addr = 32'h0040_0008;
      step(); RST = 1'b0; i_req = 1'b0;
      @(negedge CLK); chk("r_m_req_busy", {31'b0, m_req}, 32'd1);
      step(); RST = 1'b1;
      @(negedge CLK);
      chk("r_m_req", {31'b0, m_req}, 32'd0);
      chk("r_i_done", {31'b0, i_done}, 32'd0);
      chk("r_i_rdata", i_rdata, 32'd0);
      chk("r_d_rdata", d_rdata, 32'd0);
      chk("r_m_addr", m_addr, 32'd0);
      // memory never answers
      step(); i_req = 1'b1; i_addr = 32'h0040_000C;
`ifdef MEM_ARB_WATCHDOG_EN
      k = 0;
      for (int c = 1; c <= 40 && k == 0; c++) begin
         step();
         @(negedge CLK);
         if (i_done) k = c;
      end
      chk("w_done_cycle", k, TIMEOUT + 1);
      chk("w_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("w_err", {31'b0, err}, 32'd1);
      step(); i_req = 1'b0;
      step(); i_req = 1'b1;
      step(); m_ready = 1'b1; m_rdata = 32'h7777_8888;
      step(); m_ready = 1'b0;
      @(negedge CLK);
      chk("w_ok_rdata", i_rdata, 32'h7777_8888);
      step(); i_req = 1'b0;
      @(negedge CLK); chk("w_err_sticky", {31'b0, err}, 32'd1);
`else
      k = 0;
      for (int c = 1; c <= 100; c++) begin
         step();
         @(negedge CLK);
         if (m_req && stall && !err) k++;
      end
      chk("nw_held_cycles", k, 100);
      step(); RST = 1'b0; i_req = 1'b0;
      step(); RST = 1'b1;
      @(negedge CLK); chk("nw_m_req_cleared", {31'b0, m_req}, 32'd0);
`endif
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int pd;
         pd = dn;
         step();
         if ($urandom_range(0, 299) == 0) begin
            RST = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
         end else begin
            RST = 1'b1;
            if (!i_req || pd == 0) begin
               i_req = 1'($urandom_range(0, 1));
               i_addr = $urandom;
            end
            if (!d_req || pd == 1) begin
               d_req = 1'($urandom_range(0, 2) == 0);
               d_we = 1'($urandom_range(0, 1));
               d_addr = $urandom;
               d_wdata = $urandom;
            end
            m_ready = mq ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 7) == 0);
            m_rdata = $urandom;
         end
      end
      step();
      @(negedge CLK);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
